fib_seq_gen: RTL and testbench
==============================

# fib_seq_gen

Parametrised Fibonacci sequence generator: on a start command it streams terms F(0), F(1), F(2)… over a valid/ready interface until a programmed term count is reached or, optionally, until the next term no longer fits in WIDTH bits. It replaces the free-running fixed 8-bit Fibonacci counter with a resettable, back-pressurable, length-controlled source that reports overflow. It sits as a stimulus/data source feeding any valid/ready consumer in the design.

## Interface
- WIDTH, 8, term width in bits; legal range is WIDTH ≥ 2.
- CNT_W, 6, width of the term-count and index fields.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command pulse; sampled only in IDLE.
- n_terms  in  CNT_W  number of terms to emit; sampled with start.
- stop_on_ovf  in  1  selects the overflow mode; sampled with start. 1 = truncate the stream, 0 = wrap modulo 2^WIDTH.
- abort  in  1  terminates a run in progress.
- out_data  out  WIDTH  current term value.
- out_index  out  CNT_W  index i of the current term F(i).
- out_valid  out  1  term available.
- out_ready  in  1  consumer accepts the term.
- out_last  out  1  the current term is the final term of the run.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- overflow  out  1  sticky overflow flag; cleared when a run is accepted.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** state goes to IDLE. out_data, out_index, out_valid, out_last, busy, done and overflow are all 0.
- **Internal state:** a = F(i) and b = F(i+1), each WIDTH bits. Flags a_ovf and b_ovf record whether the true value of a or b is ≥ 2^WIDTH. The latched mode and latched count n are also held.
- **IDLE + start:**
  - Latch n_terms and stop_on_ovf.
  - Clear overflow.
  - If n = 0, go to DONE and emit no terms.
  - Otherwise set a=0, b=1, a_ovf=0, b_ovf=0, idx=0, and go to RUN.
- **RUN outputs:**
  - out_valid=1, out_data=a, out_index=idx.
  - out_last = (idx == n−1) OR (stop mode AND b_ovf).
- **Transfer (out_valid & out_ready):**
  - The sum a+b is computed at WIDTH+1 bits.
  - Update a←b, b←sum[WIDTH−1:0], a_ovf←b_ovf, b_ovf←b_ovf | sum[WIDTH], idx←idx+1.
- **Overflow flag:**
  - Wrap mode: set overflow on the transfer of any term with a_ovf=1.
  - Stop mode: set overflow on the transfer of a last term that was flagged by b_ovf.
- **End of run:** a transfer with out_last=1 moves the state to DONE.
- **DONE:** done=1 and out_valid=0 for exactly one cycle, then the state returns to IDLE.
- **Ignored inputs:** start is ignored while busy. n_terms and stop_on_ovf are ignored outside the start cycle.
- **abort:**
  - In RUN, go to IDLE next cycle with no done pulse; overflow keeps its value.
  - If abort and a transfer occur in the same cycle, the transfer counts (the term is consumed) and abort still wins: the next state is IDLE.
  - abort has no effect in IDLE or DONE.
- **Reset mid-run:** takes the block to the reset values on the next edge, regardless of any handshake in flight.
- **Run length:** idx never wraps, since a run ends at n−1 ≤ 2^CNT_W−2. Maximum run length is 2^CNT_W−1 terms.

## Timing
- **Start latency:** start sampled at edge t gives out_valid=1 with F(0)=0 after edge t.
- **Throughput:** one term per cycle while out_ready is held high.
- **Back-pressure:** while out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable. out_valid never drops without a transfer, except on abort or rst.
- **End of run:** if the final transfer happens at edge k, then after edge k done=1, out_valid=0, busy=1. After edge k+1, done=0 and busy=0. A new start is accepted from edge k+2.
- **n_terms=0:** start at edge t gives done after edge t and IDLE after edge t+1.
- **overflow timing:** overflow rises after the edge that transfers the qualifying term.

## Test plan
- **Basic run:** rst, then start with WIDTH=8, n=13, stop=1, ready=1 → the stream is 0,1,1,2,3,5,8,13,21,34,55,89,144. out_last is set on index 12. done pulses once and overflow=0.
- **Stop-mode truncation:** WIDTH=8, n=20, stop=1 → 14 terms ending at 233, index 13, out_last=1. overflow=1, done pulses.
- **Wrap mode:** WIDTH=8, n=16, stop=0 → index 14 = 121 and index 15 = 98 (610 mod 256). overflow rises on the index-14 transfer.
- **Back-pressure:** toggle out_ready pseudo-randomly during n=10 → data and index stay stable while stalled, and the 10 accepted terms are exactly 0…34.
- **Zero count and ignored start:** start with n=0 → done one cycle after start and no out_valid. A start pulsed mid-run is ignored.
- **abort and reset:**
  - abort coincident with the index-3 transfer → the term value 2 is consumed, IDLE next cycle, no done.
  - rst mid-run → every output returns to 0 next cycle.

Source files
------------

// File: rtl/fib_seq_gen_if.sv
// Valid/ready term stream carrying a Fibonacci value, its index and an end-of-run marker.
interface fib_seq_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
);
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_index;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Length-controlled, back-pressurable Fibonacci term source with overflow truncate/wrap modes.
module fib_seq_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_n_terms,
    input  logic             i_stop_on_ovf,
    input  logic             i_abort,
    fib_seq_gen_if.master    o_stream,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_ovf;
    logic             r_b_ovf;
    logic             r_stop;
    logic             r_overflow;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_n;
    logic [WIDTH:0]   w_sum;
    logic             w_run;
    logic             w_last;
    logic             w_xfer;
    logic             w_accept;
    logic             w_ovf_hit;

    assign w_run     = (r_state == RUN);
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_last    = w_run && ((r_idx == (r_n - CNT_W'(1))) || (r_stop && r_b_ovf));
    assign w_xfer    = w_run && o_stream.out_ready;
    assign w_accept  = (r_state == IDLE) && i_start;
    // Wrap mode flags a wrapped term as it leaves; stop mode flags the term that truncated the run.
    assign w_ovf_hit = w_xfer && (r_stop ? (w_last && r_b_ovf) : r_a_ovf);

    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next             = r_state;
        o_stream.out_valid = 1'b0;
        o_stream.out_data  = '0;
        o_stream.out_index = '0;
        o_stream.out_last  = 1'b0;
        o_busy             = 1'b0;
        o_done             = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (i_n_terms == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                o_stream.out_valid = 1'b1;
                o_stream.out_data  = r_a;
                o_stream.out_index = r_idx;
                o_stream.out_last  = w_last;
                o_busy             = 1'b1;
                // abort outranks a coincident final transfer, so no done pulse follows it
                if (i_abort) begin
                    w_next = IDLE;
                end else if (w_xfer && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_a_ovf    <= 1'b0;
            r_b_ovf    <= 1'b0;
            r_stop     <= 1'b0;
            r_overflow <= 1'b0;
            r_idx      <= '0;
            r_n        <= '0;
        end else if (w_accept) begin
            r_n        <= i_n_terms;
            r_stop     <= i_stop_on_ovf;
            r_overflow <= 1'b0;
            r_a        <= '0;
            r_b        <= WIDTH'(1);
            r_a_ovf    <= 1'b0;
            r_b_ovf    <= 1'b0;
            r_idx      <= '0;
        end else if (w_xfer) begin
            r_a     <= r_b;
            r_b     <= w_sum[WIDTH-1:0];
            r_a_ovf <= r_b_ovf;
            r_b_ovf <= r_b_ovf | w_sum[WIDTH];
            r_idx   <= r_idx + CNT_W'(1);
            if (w_ovf_hit) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: streams, truncation, wrap, back-pressure, zero count, abort and reset.
module tb_fib_seq_gen;

    localparam int WIDTH = 8;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] nTerms;
    logic             stopOnOvf;
    logic             abort;
    logic             busy;
    logic             done;
    logic             overflow;

    fib_seq_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) stream ();

    fib_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_n_terms    (nTerms),
        .i_stop_on_ovf(stopOnOvf),
        .i_abort      (abort),
        .o_stream     (stream),
        .o_busy       (busy),
        .o_done       (done),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // F(0..13) exactly, then F(14)=377 mod 256 and F(15)=610 mod 256
    int fibExp [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};

    int capData  [$];
    int capIdx   [$];
    int capLast  [$];
    int capOvf   [$];
    int capCycle [$];
    int doneCount;
    int stallCount;
    int stallBad;
    int timedOut;

    // All tasks are entered and left on a falling edge.
    task automatic doStart(input logic [CNT_W-1:0] n, input logic stop);
        start     = 1'b1;
        nTerms    = n;
        stopOnOvf = stop;
        @(negedge clk);
        start     = 1'b0;
        nTerms    = 6'd63;
        stopOnOvf = ~stop;
    endtask

    // Captures accepted terms until the run's done pulse has passed and busy drops.
    task automatic collect(input int maxCycles, input bit randReady);
        logic [31:0]      pat = 32'hB36D_4A9C;
        logic [WIDTH-1:0] heldData;
        logic [CNT_W-1:0] heldIdx;
        logic             heldLast;
        bit               held;
        bit               rdy;
        capData.delete(); capIdx.delete(); capLast.delete(); capOvf.delete(); capCycle.delete();
        doneCount = 0; stallCount = 0; stallBad = 0; timedOut = 1; held = 0;
        heldData = '0; heldIdx = '0; heldLast = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            if (done) doneCount++;
            if (done && stream.out_valid) stallBad++;
            if (held && (!stream.out_valid || stream.out_data !== heldData ||
                         stream.out_index !== heldIdx || stream.out_last !== heldLast)) stallBad++;
            if (doneCount > 0 && !busy) begin
                timedOut = 0;
                break;
            end
            rdy = randReady ? pat[c % 32] : 1'b1;
            stream.out_ready = rdy;
            held = 0;
            if (stream.out_valid) begin
                if (rdy) begin
                    capData.push_back(int'(stream.out_data));
                    capIdx.push_back(int'(stream.out_index));
                    capLast.push_back(int'(stream.out_last));
                    capOvf.push_back(int'(overflow));
                    capCycle.push_back(c);
                end else begin
                    held = 1; stallCount++;
                    heldData = stream.out_data; heldIdx = stream.out_index; heldLast = stream.out_last;
                end
            end
            @(negedge clk);
        end
        stream.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; nTerms = '0; stopOnOvf = 1'b0; abort = 1'b0;
        stream.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++; if ({stream.out_valid, stream.out_last, busy, done, overflow} !== 5'b0) begin
            nFails++; $display("[TB] FAIL reset_flags: got %b expected 00000",
                               {stream.out_valid, stream.out_last, busy, done, overflow}); end
        nChecks++; if (stream.out_data !== 8'd0) begin
            nFails++; $display("[TB] FAIL reset_data: got %0d expected 0", stream.out_data); end
        nChecks++; if (stream.out_index !== 6'd0) begin
            nFails++; $display("[TB] FAIL reset_index: got %0d expected 0", stream.out_index); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int got;
        stream.out_ready = 1'b1;
        doStart(6'd13, 1'b1);
        collect(60, 1'b0);
        nChecks++; if (timedOut !== 0) begin nFails++; $display("[TB] FAIL basic_timeout: got %0d expected 0", timedOut); end
        nChecks++; if (capData.size() !== 13) begin nFails++; $display("[TB] FAIL basic_count: got %0d expected 13", capData.size()); end
        for (int i = 0; i < 13; i++) begin
            got = (i < capData.size()) ? capData[i] : -1;
            nChecks++; if (got !== fibExp[i]) begin nFails++; $display("[TB] FAIL basic_data[%0d]: got %0d expected %0d", i, got, fibExp[i]); end
            got = (i < capIdx.size()) ? capIdx[i] : -1;
            nChecks++; if (got !== i) begin nFails++; $display("[TB] FAIL basic_index[%0d]: got %0d expected %0d", i, got, i); end
            got = (i < capLast.size()) ? capLast[i] : -1;
            nChecks++; if (got !== ((i == 12) ? 1 : 0)) begin nFails++; $display("[TB] FAIL basic_last[%0d]: got %0d expected %0d", i, got, (i == 12) ? 1 : 0); end
            got = (i < capCycle.size()) ? capCycle[i] : -1;
            nChecks++; if (got !== i) begin nFails++; $display("[TB] FAIL basic_cycle[%0d]: got %0d expected %0d", i, got, i); end
        end
        nChecks++; if (doneCount !== 1) begin nFails++; $display("[TB] FAIL basic_done: got %0d expected 1", doneCount); end
        nChecks++; if (stallBad !== 0) begin nFails++; $display("[TB] FAIL basic_valid_in_done: got %0d expected 0", stallBad); end
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL basic_overflow: got %0d expected 0", overflow); end
    endtask

    task automatic test_stop_trunc();
        int got;
        doStart(6'd20, 1'b1);
        collect(60, 1'b0);
        nChecks++; if (timedOut !== 0) begin nFails++; $display("[TB] FAIL trunc_timeout: got %0d expected 0", timedOut); end
        nChecks++; if (capData.size() !== 14) begin nFails++; $display("[TB] FAIL trunc_count: got %0d expected 14", capData.size()); end
        got = (capData.size() > 13) ? capData[13] : -1;
        nChecks++; if (got !== 233) begin nFails++; $display("[TB] FAIL trunc_final_data: got %0d expected 233", got); end
        got = (capIdx.size() > 13) ? capIdx[13] : -1;
        nChecks++; if (got !== 13) begin nFails++; $display("[TB] FAIL trunc_final_index: got %0d expected 13", got); end
        got = (capLast.size() > 13) ? capLast[13] : -1;
        nChecks++; if (got !== 1) begin nFails++; $display("[TB] FAIL trunc_final_last: got %0d expected 1", got); end
        got = (capLast.size() > 12) ? capLast[12] : -1;
        nChecks++; if (got !== 0) begin nFails++; $display("[TB] FAIL trunc_last12: got %0d expected 0", got); end
        got = (capOvf.size() > 13) ? capOvf[13] : -1;
        nChecks++; if (got !== 0) begin nFails++; $display("[TB] FAIL trunc_ovf_early: got %0d expected 0", got); end
        nChecks++; if (overflow !== 1'b1) begin nFails++; $display("[TB] FAIL trunc_overflow: got %0d expected 1", overflow); end
        nChecks++; if (doneCount !== 1) begin nFails++; $display("[TB] FAIL trunc_done: got %0d expected 1", doneCount); end
    endtask

    task automatic test_wrap();
        int got;
        doStart(6'd16, 1'b0);
        collect(60, 1'b0);
        nChecks++; if (capData.size() !== 16) begin nFails++; $display("[TB] FAIL wrap_count: got %0d expected 16", capData.size()); end
        for (int i = 12; i < 16; i++) begin
            got = (i < capData.size()) ? capData[i] : -1;
            nChecks++; if (got !== fibExp[i]) begin nFails++; $display("[TB] FAIL wrap_data[%0d]: got %0d expected %0d", i, got, fibExp[i]); end
        end
        got = (capOvf.size() > 0) ? capOvf[0] : -1;
        nChecks++; if (got !== 0) begin nFails++; $display("[TB] FAIL wrap_ovf_cleared: got %0d expected 0", got); end
        got = (capOvf.size() > 14) ? capOvf[14] : -1;
        nChecks++; if (got !== 0) begin nFails++; $display("[TB] FAIL wrap_ovf_before14: got %0d expected 0", got); end
        got = (capOvf.size() > 15) ? capOvf[15] : -1;
        nChecks++; if (got !== 1) begin nFails++; $display("[TB] FAIL wrap_ovf_after14: got %0d expected 1", got); end
        got = (capLast.size() > 13) ? capLast[13] : -1;
        nChecks++; if (got !== 0) begin nFails++; $display("[TB] FAIL wrap_no_trunc: got %0d expected 0", got); end
        got = (capLast.size() > 15) ? capLast[15] : -1;
        nChecks++; if (got !== 1) begin nFails++; $display("[TB] FAIL wrap_last15: got %0d expected 1", got); end
        nChecks++; if (doneCount !== 1) begin nFails++; $display("[TB] FAIL wrap_done: got %0d expected 1", doneCount); end
    endtask

    task automatic test_zero_count();
        doStart(6'd0, 1'b1);
        nChecks++; if ({done, busy, stream.out_valid} !== 3'b110) begin
            nFails++; $display("[TB] FAIL zero_done_cycle: got done/busy/valid=%b expected 110", {done, busy, stream.out_valid}); end
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL zero_ovf_clear: got %0d expected 0", overflow); end
        @(negedge clk);
        nChecks++; if ({done, busy, stream.out_valid} !== 3'b000) begin
            nFails++; $display("[TB] FAIL zero_idle_cycle: got done/busy/valid=%b expected 000", {done, busy, stream.out_valid}); end
    endtask

    task automatic test_backpressure();
        int got;
        doStart(6'd10, 1'b1);
        collect(200, 1'b1);
        nChecks++; if (timedOut !== 0) begin nFails++; $display("[TB] FAIL bp_timeout: got %0d expected 0", timedOut); end
        nChecks++; if (capData.size() !== 10) begin nFails++; $display("[TB] FAIL bp_count: got %0d expected 10", capData.size()); end
        for (int i = 0; i < 10; i++) begin
            got = (i < capData.size()) ? capData[i] : -1;
            nChecks++; if (got !== fibExp[i]) begin nFails++; $display("[TB] FAIL bp_data[%0d]: got %0d expected %0d", i, got, fibExp[i]); end
        end
        nChecks++; if (stallCount == 0) begin nFails++; $display("[TB] FAIL bp_stalls: got %0d expected nonzero", stallCount); end
        nChecks++; if (stallBad !== 0) begin nFails++; $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", stallBad); end
        nChecks++; if (doneCount !== 1) begin nFails++; $display("[TB] FAIL bp_done: got %0d expected 1", doneCount); end
    endtask

    task automatic test_ignored_start();
        int got;
        stream.out_ready = 1'b0;
        doStart(6'd5, 1'b1);
        stream.out_ready = 1'b0;
        start = 1'b1; nTerms = 6'd2; stopOnOvf = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nChecks++; if ({stream.out_valid, stream.out_index} !== {1'b1, 6'd0}) begin
            nFails++; $display("[TB] FAIL ign_hold: got valid=%0d index=%0d expected valid=1 index=0", stream.out_valid, stream.out_index); end
        collect(40, 1'b0);
        nChecks++; if (capData.size() !== 5) begin nFails++; $display("[TB] FAIL ign_count: got %0d expected 5", capData.size()); end
        got = (capLast.size() > 1) ? capLast[1] : -1;
        nChecks++; if (got !== 0) begin nFails++; $display("[TB] FAIL ign_last1: got %0d expected 0", got); end
        got = (capData.size() > 4) ? capData[4] : -1;
        nChecks++; if (got !== 3) begin nFails++; $display("[TB] FAIL ign_data4: got %0d expected 3", got); end
    endtask

    task automatic test_abort();
        stream.out_ready = 1'b1;
        doStart(6'd10, 1'b1);
        repeat (3) @(negedge clk);
        nChecks++; if ({stream.out_valid, stream.out_index, stream.out_data} !== {1'b1, 6'd3, 8'd2}) begin
            nFails++; $display("[TB] FAIL abort_term3: got valid=%0d index=%0d data=%0d expected 1/3/2",
                               stream.out_valid, stream.out_index, stream.out_data); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        nChecks++; if ({busy, done, stream.out_valid} !== 3'b000) begin
            nFails++; $display("[TB] FAIL abort_idle: got busy/done/valid=%b expected 000", {busy, done, stream.out_valid}); end
        @(negedge clk);
        nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done); end
        doStart(6'd20, 1'b0);
        repeat (16) @(negedge clk);
        nChecks++; if ({overflow, stream.out_index} !== {1'b1, 6'd16}) begin
            nFails++; $display("[TB] FAIL abort_wrap_pre: got ovf=%0d index=%0d expected 1/16", overflow, stream.out_index); end
        stream.out_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        stream.out_ready = 1'b1;
        nChecks++; if ({busy, overflow} !== 2'b01) begin
            nFails++; $display("[TB] FAIL abort_ovf_kept: got busy/ovf=%b expected 01", {busy, overflow}); end
        @(negedge clk);
        nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL abort2_no_done: got %0d expected 0", done); end
    endtask

    task automatic test_reset_midrun();
        doStart(6'd20, 1'b0);
        repeat (16) @(negedge clk);
        nChecks++; if ({busy, overflow, stream.out_valid} !== 3'b111) begin
            nFails++; $display("[TB] FAIL rstmid_pre: got busy/ovf/valid=%b expected 111", {busy, overflow, stream.out_valid}); end
        rst = 1'b1;
        @(negedge clk);
        nChecks++; if ({stream.out_valid, stream.out_last, busy, done, overflow} !== 5'b0) begin
            nFails++; $display("[TB] FAIL rstmid_flags: got %b expected 00000",
                               {stream.out_valid, stream.out_last, busy, done, overflow}); end
        nChecks++; if ({stream.out_data, stream.out_index} !== 14'd0) begin
            nFails++; $display("[TB] FAIL rstmid_data_index: got data=%0d index=%0d expected 0/0",
                               stream.out_data, stream.out_index); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stop_trunc();
        test_wrap();
        test_zero_count();
        test_backpressure();
        test_ignored_start();
        test_abort();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
